// File: rtl/mem_wb_stage.sv
// Y86-64 memory stage and M-to-W pipeline register.
// Data memory is reached over a req/ack handshake; the stage stalls upstream while an access is outstanding.
module mem_wb_stage #(
  parameter logic [63:0] MEM_BYTES = 64'h1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  m_icode,
  input  logic [3:0]  m_rA,
  input  logic [3:0]  m_rB,
  input  logic [63:0] m_valA,
  input  logic [63:0] m_valE,
  input  logic [63:0] m_valP,
  input  logic        m_cnd,
  input  logic [1:0]  m_stat,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  input  logic        dmem_err,
  output logic        mem_stall,
  output logic [3:0]  w_icode,
  output logic [3:0]  w_rA,
  output logic [3:0]  w_rB,
  output logic [63:0] w_valE,
  output logic [63:0] w_valM,
  output logic        w_cnd,
  output logic [1:0]  w_stat
);

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [63:0] LAST_LEGAL = MEM_BYTES - 64'd8;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_reg;
  logic        halted_reg;

  logic        is_read;
  logic        is_write;
  logic [63:0] acc_addr;
  logic [63:0] acc_wdata;
  logic        access_needed;
  logic        addr_legal;
  logic        issue;
  logic        w_load;
  logic [63:0] valm_next;
  logic [1:0]  stat_next;

  always_comb begin
    is_read   = 1'b0;
    is_write  = 1'b0;
    acc_addr  = m_valE;
    acc_wdata = 64'd0;
    case (m_icode)
      4'h4, 4'hA: begin is_write = 1'b1; acc_wdata = m_valA; end
      4'h8:       begin is_write = 1'b1; acc_wdata = m_valP; end
      4'h5:       is_read = 1'b1;
      4'h9, 4'hB: begin is_read = 1'b1; acc_addr = m_valA; end
      default:    ;
    endcase
  end

  assign access_needed = (is_read | is_write) && (m_stat == STAT_AOK) && !halted_reg;
  assign addr_legal    = (acc_addr <= LAST_LEGAL);

  // No request is ever issued while reset is held, so nothing upstream should stall either.
  assign mem_stall = !reset && ((state_reg == IDLE) ? (access_needed && addr_legal) : !dmem_ack);

  always_comb begin
    issue     = 1'b0;
    w_load    = 1'b0;
    valm_next = 64'd0;
    stat_next = STAT_AOK;
    if (state_reg == IDLE) begin
      if (!halted_reg) begin
        if (access_needed) begin
          if (addr_legal) begin
            issue = 1'b1;
          end else begin
            w_load    = 1'b1;
            stat_next = STAT_ADR;
          end
        end else begin
          w_load    = 1'b1;
          stat_next = m_stat;
        end
      end
    end else if (dmem_ack) begin
      w_load    = 1'b1;
      valm_next = is_read ? dmem_rdata : 64'd0;
      stat_next = dmem_err ? STAT_ADR : STAT_AOK;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      halted_reg <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 64'd0;
      dmem_wdata <= 64'd0;
      w_icode    <= 4'h1;
      w_rA       <= 4'hF;
      w_rB       <= 4'hF;
      w_valE     <= 64'd0;
      w_valM     <= 64'd0;
      w_cnd      <= 1'b0;
      w_stat     <= STAT_AOK;
    end else begin
      case (state_reg)
        IDLE: if (issue) begin
          dmem_req   <= 1'b1;
          dmem_we    <= is_write;
          dmem_addr  <= acc_addr;
          dmem_wdata <= acc_wdata;
          state_reg  <= WAIT;
        end
        WAIT: if (dmem_ack) begin
          dmem_req  <= 1'b0;
          dmem_we   <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      if (w_load) begin
        w_icode <= m_icode;
        w_rA    <= m_rA;
        w_rB    <= m_rB;
        w_valE  <= m_valE;
        w_valM  <= valm_next;
        w_cnd   <= m_cnd;
        w_stat  <= stat_next;
      end else begin
        w_icode <= 4'h1;
        w_rA    <= 4'hF;
        w_rB    <= 4'hF;
        w_valE  <= 64'd0;
        w_valM  <= 64'd0;
        w_cnd   <= 1'b0;
        w_stat  <= STAT_AOK;
      end

      // Any non-AOK status reaching W freezes the stage until reset.
      if (w_load && (stat_next != STAT_AOK))
        halted_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage against a transaction-level model of the memory stage.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  m_icode, m_rA, m_rB;
  logic [63:0] m_valA, m_valE, m_valP;
  logic        m_cnd;
  logic [1:0]  m_stat;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        dmem_err;
  logic        mem_stall;
  logic [3:0]  w_icode, w_rA, w_rB;
  logic [63:0] w_valE, w_valM;
  logic        w_cnd;
  logic [1:0]  w_stat;

  int n_vec = 0;
  int n_err = 0;
  bit halted_m = 1'b0;

  typedef struct {
    logic [3:0]  icode, rA, rB;
    logic [63:0] valA, valE, valP;
    logic        cnd;
    logic [1:0]  stat;
  } instr_t;

  mem_wb_stage dut (
    .clk(clk), .reset(reset),
    .m_icode(m_icode), .m_rA(m_rA), .m_rB(m_rB),
    .m_valA(m_valA), .m_valE(m_valE), .m_valP(m_valP),
    .m_cnd(m_cnd), .m_stat(m_stat),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
    .mem_stall(mem_stall),
    .w_icode(w_icode), .w_rA(w_rA), .w_rB(w_rB), .w_valE(w_valE), .w_valM(w_valM),
    .w_cnd(w_cnd), .w_stat(w_stat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic cnd, input logic [1:0] st, input logic [63:0] ve, input logic [63:0] vm);
    check({tag, "_ctl"}, {49'd0, w_icode, w_rA, w_rB, w_cnd, w_stat}, {49'd0, ic, ra, rb, cnd, st});
    check({tag, "_valE"}, w_valE, ve);
    check({tag, "_valM"}, w_valM, vm);
  endtask

  task automatic check_bubble(input string tag);
    check_w(tag, 4'h1, 4'hF, 4'hF, 1'b0, 2'd0, 64'd0, 64'd0);
  endtask

  // kind: 0 none, 1 read, 2 write
  function automatic void model_access(input instr_t t, output int kind,
                                       output logic [63:0] addr, output logic [63:0] wdata);
    kind = 0; addr = t.valE; wdata = 64'd0;
    if (t.icode == 4'h4 || t.icode == 4'hA) begin kind = 2; wdata = t.valA; end
    else if (t.icode == 4'h8) begin kind = 2; wdata = t.valP; end
    else if (t.icode == 4'h5) kind = 1;
    else if (t.icode == 4'h9 || t.icode == 4'hB) begin kind = 1; addr = t.valA; end
  endfunction

  task automatic drive_m(input instr_t t);
    m_icode = t.icode; m_rA = t.rA; m_rB = t.rB;
    m_valA = t.valA; m_valE = t.valE; m_valP = t.valP;
    m_cnd = t.cnd; m_stat = t.stat;
  endtask

  function automatic instr_t nop_instr();
    instr_t t;
    t.icode = 4'h1; t.rA = 4'hF; t.rB = 4'hF;
    t.valA = 64'd0; t.valE = 64'd0; t.valP = 64'd0; t.cnd = 1'b0; t.stat = 2'd0;
    return t;
  endfunction

  function automatic instr_t mk(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                                input logic [63:0] va, input logic [63:0] ve, input logic [63:0] vp,
                                input logic [1:0] st);
    instr_t t;
    t.icode = ic; t.rA = ra; t.rB = rb; t.valA = va; t.valE = ve; t.valP = vp;
    t.cnd = 1'b1; t.stat = st;
    return t;
  endfunction

  // One instruction through the stage; delay is the number of WAIT cycles until ack.
  task automatic run_instr(input string tag, input instr_t t, input int delay,
                           input logic err, input logic [63:0] rdata);
    int kind;
    logic [63:0] addr, wdata;
    bit needs, legal;
    logic [1:0] st;
    model_access(t, kind, addr, wdata);
    needs = (kind != 0) && (t.stat == 2'd0) && !halted_m;
    legal = (addr <= 64'h1000 - 64'd8);
    @(negedge clk);
    drive_m(t);
    dmem_ack = 1'($urandom);
    dmem_rdata = {$urandom, $urandom};
    dmem_err = 1'($urandom);
    #1;
    if (needs && legal) begin
      check({tag, "_stall_issue"}, 64'(mem_stall), 64'd1);
      @(posedge clk); #1;
      check({tag, "_req"}, 64'(dmem_req), 64'd1);
      check({tag, "_we"}, 64'(dmem_we), (kind == 2) ? 64'd1 : 64'd0);
      check({tag, "_addr"}, dmem_addr, addr);
      if (kind == 2) check({tag, "_wdata"}, dmem_wdata, wdata);
      check_bubble({tag, "_issue_w"});
      for (int k = 1; k <= delay; k++) begin
        @(negedge clk);
        dmem_ack = (k == delay);
        dmem_rdata = rdata;
        dmem_err = err;
        #1;
        check({tag, "_stall_wait"}, 64'(mem_stall), (k == delay) ? 64'd0 : 64'd1);
        @(posedge clk); #1;
        if (k < delay) begin
          check_bubble({tag, "_wait_w"});
          check({tag, "_req_held"}, 64'(dmem_req), 64'd1);
          check({tag, "_addr_held"}, dmem_addr, addr);
        end else begin
          st = err ? 2'd2 : 2'd0;
          check_w({tag, "_done_w"}, t.icode, t.rA, t.rB, t.cnd, st, t.valE,
                  (kind == 1) ? rdata : 64'd0);
          check({tag, "_req_clr"}, 64'(dmem_req), 64'd0);
          if (st != 2'd0) halted_m = 1'b1;
        end
      end
      dmem_ack = 1'b0;
    end else begin
      check({tag, "_stall"}, 64'(mem_stall), 64'd0);
      @(posedge clk); #1;
      check({tag, "_noreq"}, 64'(dmem_req), 64'd0);
      if (halted_m) begin
        check_bubble({tag, "_halted_w"});
      end else begin
        st = needs ? 2'd2 : t.stat;
        check_w({tag, "_w"}, t.icode, t.rA, t.rB, t.cnd, st, t.valE, 64'd0);
        if (st != 2'd0) halted_m = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    instr_t t;
    @(negedge clk);
    reset = 1'b1;
    t = mk(4'h5, 4'($urandom), 4'($urandom), 64'h80, 64'h100, {$urandom, $urandom}, 2'd0);
    drive_m(t);
    dmem_ack = 1'($urandom);
    dmem_rdata = {$urandom, $urandom};
    dmem_err = 1'($urandom);
    #1;
    check("rst_req", 64'(dmem_req), 64'd0);
    check("rst_stall", 64'(mem_stall), 64'd0);
    check_bubble("rst_w");
    @(posedge clk); #1;
    check("rst_req_edge", 64'(dmem_req), 64'd0);
    check_bubble("rst_w_edge");
    @(negedge clk);
    drive_m(nop_instr());
    dmem_ack = 1'b0;
    reset = 1'b0;
    halted_m = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic reset_mid_wait();
    @(negedge clk);
    drive_m(mk(4'h5, 4'h0, 4'h3, 64'd0, 64'h200, 64'd0, 2'd0));
    dmem_ack = 1'b0;
    #1 check("rmw_stall", 64'(mem_stall), 64'd1);
    @(posedge clk); #1;
    check("rmw_req", 64'(dmem_req), 64'd1);
    @(negedge clk);
    drive_m(nop_instr());
    reset = 1'b1;
    #1;
    check("rmw_req_async", 64'(dmem_req), 64'd0);
    check_bubble("rmw_w_async");
    #1 reset = 1'b0;
    #1 check("rmw_idle_stall", 64'(mem_stall), 64'd0);
    @(posedge clk); #1;
    check("rmw_req_post", 64'(dmem_req), 64'd0);
    @(negedge clk);
    dmem_ack = 1'b1;
    dmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    dmem_err = 1'b1;
    #1 check("rmw_late_ack_stall", 64'(mem_stall), 64'd0);
    @(posedge clk); #1;
    check_bubble("rmw_late_ack_w");
    check("rmw_late_ack_req", 64'(dmem_req), 64'd0);
    dmem_ack = 1'b0;
    halted_m = 1'b0;
  endtask

  function automatic logic [63:0] pick_addr();
    case ($urandom % 8)
      0: return 64'hFF8;
      1: return 64'hFF9 + 64'($urandom % 16);
      2: return {$urandom, $urandom};
      default: return 64'($urandom % 32'hFF9);
    endcase
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    logic [3:0] ops [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    t.icode = ops[$urandom % 10];
    t.rA = 4'($urandom); t.rB = 4'($urandom);
    t.valA = pick_addr(); t.valE = pick_addr(); t.valP = {$urandom, $urandom};
    t.cnd = 1'($urandom);
    t.stat = (($urandom % 10) == 0) ? 2'($urandom) : 2'd0;
    return t;
  endfunction

  initial begin
    reset = 1'b1;
    drive_m(nop_instr());
    dmem_ack = 1'b0; dmem_rdata = 64'd0; dmem_err = 1'b0;
    do_reset();

    run_instr("irmovq", mk(4'h3, 4'hF, 4'h2, 64'd0, 64'd5, 64'd0, 2'd0), 1, 1'b0, 64'd0);
    run_instr("mrmovq", mk(4'h5, 4'h1, 4'h4, 64'd0, 64'h100, 64'd0, 2'd0), 3, 1'b0, 64'hDEAD);
    run_instr("call", mk(4'h8, 4'hF, 4'h4, 64'd0, 64'h1F8, 64'h40, 2'd0), 1, 1'b0, 64'h1234);
    run_instr("rm_last_legal", mk(4'h4, 4'h1, 4'h2, 64'hCAFE, 64'hFF8, 64'd0, 2'd0), 2, 1'b0, 64'd0);
    run_instr("rm_illegal", mk(4'h4, 4'h1, 4'h2, 64'hCAFE, 64'hFF9, 64'd0, 2'd0), 1, 1'b0, 64'd0);
    run_instr("rm_after_halt", mk(4'h4, 4'h1, 4'h2, 64'hBEEF, 64'h10, 64'd0, 2'd0), 1, 1'b0, 64'd0);
    do_reset();
    run_instr("popq_err", mk(4'hB, 4'h3, 4'hF, 64'h300, 64'h308, 64'd0, 2'd0), 2, 1'b1, 64'h77);
    do_reset();
    reset_mid_wait();

    for (int i = 0; i < 400; i++) begin
      if (($urandom % 25) == 0 || (halted_m && ($urandom % 3) == 0))
        do_reset();
      else
        run_instr("rand", rand_instr(), 1 + int'($urandom % 4), (($urandom % 6) == 0),
                  {$urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
